// File: rtl/lsu_bus_master_pkg.sv
// Shared definitions for the M-stage load/store bus initiator: encodings,
// address map, state type and the request-building helpers.
package lsu_bus_master_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned BE_W  = 4;
    localparam int unsigned EXC_W = 5;
    localparam int unsigned LS_W  = 3;

    localparam logic [XLEN-1:0] ADDR_DM_HI  = 32'h0000_2fff;
    localparam logic [XLEN-1:0] ADDR_DEV_LO = 32'h0000_7f00;
    localparam logic [XLEN-1:0] ADDR_DEV_HI = 32'h0000_7f1b;

    localparam logic [LS_W-1:0] LS_WORD  = 3'b000;
    localparam logic [LS_W-1:0] LS_HALF  = 3'b001;
    localparam logic [LS_W-1:0] LS_HALFU = 3'b010;
    localparam logic [LS_W-1:0] LS_BYTE  = 3'b011;
    localparam logic [LS_W-1:0] LS_BYTEU = 3'b100;

    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } bus_cmd_t;

    // Alignment plus address-map check; devices only take full words.
    function automatic logic addr_legal(input logic [LS_W-1:0] lstype,
                                        input logic [XLEN-1:0] addr);
        logic in_dm;
        logic in_dev;
        logic aligned;
        in_dm  = (addr <= ADDR_DM_HI);
        in_dev = (addr >= ADDR_DEV_LO) && (addr <= ADDR_DEV_HI);
        case (lstype)
            LS_WORD:           aligned = (addr[1:0] == 2'b00);
            LS_HALF, LS_HALFU: aligned = !addr[0];
            LS_BYTE, LS_BYTEU: aligned = 1'b1;
            default:           aligned = 1'b0;
        endcase
        return aligned && (in_dm || (in_dev && (lstype == LS_WORD)));
    endfunction

    // Word-aligned request with lane enables and replicated store data.
    function automatic bus_cmd_t build_cmd(input logic            we,
                                           input logic [LS_W-1:0] lstype,
                                           input logic [XLEN-1:0] addr,
                                           input logic [XLEN-1:0] wd);
        bus_cmd_t        cmd;
        logic [BE_W-1:0] lanes;
        cmd.we   = we;
        cmd.addr = {addr[XLEN-1:2], 2'b00};
        case (lstype)
            LS_WORD: begin
                lanes     = 4'b1111;
                cmd.wdata = wd;
            end
            LS_HALF, LS_HALFU: begin
                lanes     = addr[1] ? 4'b1100 : 4'b0011;
                cmd.wdata = {2{wd[15:0]}};
            end
            default: begin
                lanes     = 4'b0001 << addr[1:0];
                cmd.wdata = {4{wd[7:0]}};
            end
        endcase
        cmd.be = we ? lanes : 4'b0000;
        return cmd;
    endfunction

endpackage

// File: rtl/lsu_lane_extract.sv
// Selects the addressed half/byte from a read word and sign- or
// zero-extends it according to the load type.
module lsu_lane_extract
    import lsu_bus_master_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [LS_W-1:0] lstype,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data
);

    logic [15:0] lane16;
    logic [7:0]  lane8;

    always_comb begin
        lane16 = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        lane8  = rdata[{addr_lo, 3'b000} +: 8];
        case (lstype)
            LS_HALF:  data = {{16{lane16[15]}}, lane16};
            LS_HALFU: data = {16'h0000, lane16};
            LS_BYTE:  data = {{24{lane8[7]}}, lane8};
            LS_BYTEU: data = {24'h00_0000, lane8};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// M-stage load/store initiator: checks the access, runs one bus request,
// stalls the pipeline until the responder acks and returns extended data.
module lsu_bus_master
    import lsu_bus_master_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req,
    input  logic             WE,
    input  logic [LS_W-1:0]  LStype,
    input  logic [XLEN-1:0]  Addr,
    input  logic [XLEN-1:0]  WD,
    input  logic             Flush,
    output logic             Stall,
    output logic             Done,
    output logic [XLEN-1:0]  RD,
    output logic             ExcValid,
    output logic [EXC_W-1:0] ExcCode,
    output logic             bus_req,
    output logic             bus_we,
    output logic [XLEN-1:0]  bus_addr,
    output logic [BE_W-1:0]  bus_be,
    output logic [XLEN-1:0]  bus_wdata,
    input  logic             bus_ack,
    input  logic [XLEN-1:0]  bus_rdata
);

    state_e          state;
    bus_cmd_t        cmd;
    logic [LS_W-1:0] op_type;
    logic [1:0]      op_lo;
    logic            legal;
    logic            idle_req;
    logic            accept;
    logic [XLEN-1:0] load_data;

    lsu_lane_extract u_extract (
        .rdata   (bus_rdata),
        .lstype  (op_type),
        .addr_lo (op_lo),
        .data    (load_data)
    );

    // Exception and stall paths are zero-latency; gated by reset so a reset
    // with Req still high presents quiet outputs.
    always_comb begin
        legal    = addr_legal(LStype, Addr);
        idle_req = (state == ST_IDLE) && Req && !Flush && !Reset;
        accept   = idle_req && legal;
        ExcValid = idle_req && !legal;
        ExcCode  = ExcValid ? (WE ? EXC_ADES : EXC_ADEL) : '0;
        Stall    = accept || (state == ST_BUS) || ((state == ST_DRAIN) && Req && !Reset);
        Done     = (state == ST_DONE);
    end

    assign bus_req   = (state == ST_BUS) || (state == ST_DRAIN);
    assign bus_we    = cmd.we;
    assign bus_addr  = cmd.addr;
    assign bus_be    = cmd.be;
    assign bus_wdata = cmd.wdata;

    // Transaction sequencing; a flushed request still has to be drained.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            cmd     <= '0;
            op_type <= '0;
            op_lo   <= '0;
            RD      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd     <= build_cmd(WE, LStype, Addr, WD);
                        op_type <= LStype;
                        op_lo   <= Addr[1:0];
                        state   <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (bus_ack) begin
                        if (Flush) begin
                            state <= ST_IDLE;
                        end else begin
                            if (!cmd.we) RD <= load_data;
                            state <= ST_DONE;
                        end
                    end else if (Flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                ST_DRAIN: if (bus_ack) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master: directed ops push expected bus
// requests and responses; monitors pop and compare as the DUT presents them.
module tb_lsu_bus_master;
    import lsu_bus_master_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Req = 1'b0;
    logic        WE = 1'b0;
    logic [2:0]  LStype = 3'b000;
    logic [31:0] Addr = 32'h0;
    logic [31:0] WD = 32'h0;
    logic        Flush = 1'b0;
    logic        Stall;
    logic        Done;
    logic [31:0] RD;
    logic        ExcValid;
    logic [4:0]  ExcCode;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    typedef struct {
        logic        is_exc;
        logic [31:0] rd;
        logic [4:0]  code;
    } res_exp_t;

    bus_cmd_t    bus_q[$];
    res_exp_t    res_q[$];
    bus_cmd_t    mon_cmd;
    res_exp_t    mon_res;
    int          checks = 0;
    int          failures = 0;
    int          ack_delay = 0;
    int          resp_cnt = 0;
    logic [31:0] rdata_val = 32'h0;
    logic [31:0] last_rd = 32'h0;
    int          stalls;

    lsu_bus_master dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req       (Req),
        .WE        (WE),
        .LStype    (LStype),
        .Addr      (Addr),
        .WD        (WD),
        .Flush     (Flush),
        .Stall     (Stall),
        .Done      (Done),
        .RD        (RD),
        .ExcValid  (ExcValid),
        .ExcCode   (ExcCode),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder: acks on request cycle ack_delay+1.
    always @(posedge Clk) begin
        #2;
        if (bus_req) begin
            resp_cnt++;
            bus_ack   = (resp_cnt == ack_delay + 1);
            bus_rdata = rdata_val;
        end else begin
            resp_cnt = 0;
            bus_ack  = 1'b0;
        end
    end

    // Bus monitor: compare request fields on the first request cycle.
    always @(negedge Clk) begin
        if (!Reset && bus_req && resp_cnt == 1) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_bus_req", 32'(bus_req), 32'h0);
            end else begin
                mon_cmd = bus_q.pop_front();
                chk("bus_we", 32'(bus_we), 32'(mon_cmd.we));
                chk("bus_addr", bus_addr, mon_cmd.addr);
                chk("bus_be", 32'(bus_be), 32'(mon_cmd.be));
                if (mon_cmd.we) chk("bus_wdata", bus_wdata, mon_cmd.wdata);
            end
        end
    end

    // Response monitor: every Done or ExcValid pulse must match the next expectation.
    always @(negedge Clk) begin
        if (!Reset && (Done || ExcValid)) begin
            if (res_q.size() == 0) begin
                chk("unexpected_response", {30'h0, Done, ExcValid}, 32'h0);
            end else begin
                mon_res = res_q.pop_front();
                chk("resp_is_exc", 32'(ExcValid), 32'(mon_res.is_exc));
                chk("resp_done", 32'(Done), 32'(!mon_res.is_exc));
                chk("resp_code", 32'(ExcCode), 32'(mon_res.code));
                if (!mon_res.is_exc) chk("resp_rd", RD, mon_res.rd);
            end
        end
    end

    // One pipeline op: hold Req while stalled, then release it.
    task automatic do_op(input logic we, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] wd, input int dly, input logic [31:0] rdat,
                         input logic [4:0] exp_code, input logic [31:0] exp_rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         output int n_stall);
        int n;
        ack_delay = dly;
        rdata_val = rdat;
        if (exp_code == 5'd0) begin
            bus_q.push_back('{we: we, addr: {a[31:2], 2'b00}, be: exp_be, wdata: exp_wdata});
            if (!we) last_rd = exp_rd;
            res_q.push_back('{is_exc: 1'b0, rd: last_rd, code: 5'd0});
        end else begin
            res_q.push_back('{is_exc: 1'b1, rd: 32'h0, code: exp_code});
        end
        @(posedge Clk); #1;
        Req = 1'b1; WE = we; LStype = t; Addr = a; WD = wd;
        n_stall = 0;
        n = 0;
        do begin
            @(negedge Clk);
            if (Stall) n_stall++;
            n++;
        end while (Stall && n < 50);
        chk("op_stall_release", 32'(Stall), 32'h0);
        @(posedge Clk); #1;
        Req = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        chk("rst_rd", RD, 32'h0);
        chk("rst_done", 32'(Done), 32'h0);
        chk("rst_stall", 32'(Stall), 32'h0);
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", 32'(bus_be), 32'h0);
        chk("rst_exc", {27'h0, ExcCode}, 32'h0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        // Loads
        do_op(1'b0, LS_WORD,  32'h0000_0010, 32'h0, 1, 32'h8765_4321, 5'd0, 32'h8765_4321, 4'h0, 32'h0, stalls);
        chk("lw_stall_cycles", 32'(stalls), 32'd3);
        do_op(1'b0, LS_BYTE,  32'h0000_0013, 32'h0, 0, 32'h8012_3456, 5'd0, 32'hFFFF_FF80, 4'h0, 32'h0, stalls);
        chk("lb_stall_cycles", 32'(stalls), 32'd2);
        do_op(1'b0, LS_BYTEU, 32'h0000_0013, 32'h0, 2, 32'h8012_3456, 5'd0, 32'h0000_0080, 4'h0, 32'h0, stalls);
        do_op(1'b0, LS_HALF,  32'h0000_0002, 32'h0, 0, 32'h8001_1234, 5'd0, 32'hFFFF_8001, 4'h0, 32'h0, stalls);
        do_op(1'b0, LS_HALFU, 32'h0000_2002, 32'h0, 1, 32'h8001_1234, 5'd0, 32'h0000_8001, 4'h0, 32'h0, stalls);
        do_op(1'b0, LS_WORD,  32'h0000_7f10, 32'h0, 0, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 4'h0, 32'h0, stalls);

        // Stores
        do_op(1'b1, LS_BYTE,  32'h0000_0005, 32'h0000_00AB, 0, 32'h0, 5'd0, 32'h0, 4'b0010, 32'hABAB_ABAB, stalls);
        do_op(1'b1, LS_HALF,  32'h0000_0006, 32'h1234_5678, 1, 32'h0, 5'd0, 32'h0, 4'b1100, 32'h5678_5678, stalls);
        do_op(1'b1, LS_WORD,  32'h0000_2ffc, 32'hCAFE_F00D, 0, 32'h0, 5'd0, 32'h0, 4'b1111, 32'hCAFE_F00D, stalls);
        do_op(1'b1, LS_BYTEU, 32'h0000_0002, 32'h0000_005A, 0, 32'h0, 5'd0, 32'h0, 4'b0100, 32'h5A5A_5A5A, stalls);

        // Address exceptions
        do_op(1'b0, LS_WORD,  32'h0000_0002, 32'h0, 0, 32'h0, 5'd4, 32'h0, 4'h0, 32'h0, stalls);
        chk("exc_no_stall", 32'(stalls), 32'd0);
        do_op(1'b1, LS_WORD,  32'h0000_4000, 32'h0, 0, 32'h0, 5'd5, 32'h0, 4'h0, 32'h0, stalls);
        do_op(1'b1, LS_HALF,  32'h0000_7f04, 32'h0, 0, 32'h0, 5'd5, 32'h0, 4'h0, 32'h0, stalls);
        do_op(1'b0, LS_BYTE,  32'h0000_3000, 32'h0, 0, 32'h0, 5'd4, 32'h0, 4'h0, 32'h0, stalls);
        do_op(1'b0, LS_WORD,  32'h0000_7f1c, 32'h0, 0, 32'h0, 5'd4, 32'h0, 4'h0, 32'h0, stalls);
        do_op(1'b0, 3'b101,   32'h0000_0000, 32'h0, 0, 32'h0, 5'd4, 32'h0, 4'h0, 32'h0, stalls);

        // Flush one cycle into BUS; ack arrives on request cycle 4
        ack_delay = 3;
        rdata_val = 32'h1111_1111;
        bus_q.push_back('{we: 1'b0, addr: 32'h0000_0040, be: 4'h0, wdata: 32'h0});
        @(posedge Clk); #1;
        Req = 1'b1; WE = 1'b0; LStype = LS_WORD; Addr = 32'h0000_0040; WD = 32'h0;
        @(posedge Clk); #1;
        Flush = 1'b1;
        @(posedge Clk); #1;
        Flush = 1'b0; LStype = LS_BYTEU; Addr = 32'h0000_0007;
        begin
            int n;
            n = 0;
            do begin
                @(negedge Clk);
                chk("drain_stall", 32'(Stall), 32'h1);
                chk("drain_bus_req", 32'(bus_req), 32'h1);
                chk("drain_no_done", 32'(Done), 32'h0);
                n++;
            end while (!bus_ack && n < 20);
            chk("drain_ack_seen", 32'(bus_ack), 32'h1);
        end
        @(posedge Clk); #1;
        Req = 1'b0;
        @(negedge Clk);
        chk("drain_rd_unchanged", RD, 32'hDEAD_BEEF);
        chk("drain_idle_no_req", 32'(bus_req), 32'h0);
        do_op(1'b0, LS_BYTEU, 32'h0000_0007, 32'h0, 0, 32'h7F00_0000, 5'd0, 32'h0000_007F, 4'h0, 32'h0, stalls);

        // Reset while a request is outstanding
        ack_delay = 10;
        bus_q.push_back('{we: 1'b0, addr: 32'h0000_0044, be: 4'h0, wdata: 32'h0});
        @(posedge Clk); #1;
        Req = 1'b1; WE = 1'b0; LStype = LS_WORD; Addr = 32'h0000_0044;
        @(negedge Clk);
        @(negedge Clk);
        chk("pre_rst_bus_req", 32'(bus_req), 32'h1);
        #1 Reset = 1'b1;
        #1;
        chk("mid_rst_bus_req", 32'(bus_req), 32'h0);
        chk("mid_rst_stall", 32'(Stall), 32'h0);
        chk("mid_rst_rd", RD, 32'h0);
        chk("mid_rst_bus_addr", bus_addr, 32'h0);
        chk("mid_rst_bus_be", 32'(bus_be), 32'h0);
        chk("mid_rst_exc", {26'h0, ExcValid, ExcCode}, 32'h0);
        Req = 1'b0;
        last_rd = 32'h0;
        @(posedge Clk); #1;
        Reset = 1'b0;

        do_op(1'b0, LS_WORD, 32'h0000_0020, 32'h0, 0, 32'h0000_0001, 5'd0, 32'h0000_0001, 4'h0, 32'h0, stalls);
        chk("post_rst_stall_cycles", 32'(stalls), 32'd2);

        repeat (3) @(negedge Clk);
        chk("res_q_drained", 32'(res_q.size()), 32'h0);
        chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
